// File: rtl/audio_rec_play_ctrl_if.sv
// Buffer-side port of the record/playback controller: write and read strobes,
// data and address-reset pulses toward the SDRAM FIFO controller.
interface audio_rec_play_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_load;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_load;

    modport master (
        output wr_en, wr_data, wr_load, rd_en, rd_load,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_data, wr_load, rd_en, rd_load,
        output rd_data
    );
endinterface

// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer between the codec rx/tx path and the SDRAM FIFO.
// Frames are serialised into CHANNELS consecutive buffer words, ch0 first.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for record key (priority) or a play request
// S_REC  | record key held; each rx event writes one frame burst
// S_PLAY | each tx event reads one frame burst into dac_data
module audio_rec_play_ctrl #(
    parameter int                  DATA_W     = 16,
    parameter int                  CHANNELS   = 2,
    parameter int                  FRAME_W    = 24,
    parameter logic [FRAME_W-1:0]  MAX_FRAMES = 24'd480000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_ready,
    input  logic                         record_key,
    input  logic                         play_key,
    input  logic                         loop_en,
    input  logic                         rx_done,
    input  logic                         tx_done,
    input  logic [CHANNELS*DATA_W-1:0]   adc_data,
    output logic [CHANNELS*DATA_W-1:0]   dac_data,
    audio_rec_play_ctrl_if.master        buf_if,
    output logic [1:0]                   state,
    output logic                         rec_full,
    output logic [FRAME_W-1:0]           rec_len
);
    localparam int BEAT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    logic mem_ready_d0, mem_ready_d1;
    logic record_key_d0, record_key_d1;
    logic play_key_d0, play_key_d1;
    logic rx_d0, rx_d1;
    logic tx_d0, tx_d1;
    logic pos_rx, pos_tx, neg_play;

    state_t             st, st_nxt;
    logic [BEAT_W-1:0]  beat, beat_nxt;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;
    logic [FRAME_W-1:0] play_cnt, play_cnt_nxt;
    logic [FRAME_W-1:0] rec_len_nxt;
    logic               rec_full_nxt;
    logic               wr_en, wr_en_nxt;
    logic [DATA_W-1:0]  wr_data, wr_data_nxt;
    logic               wr_load, wr_load_nxt;
    logic               rd_en, rd_en_nxt;
    logic               rd_load, rd_load_nxt;
    logic               dac_pend, dac_pend_nxt;
    logic [CHANNELS*DATA_W-1:0] dac_nxt;
    logic [DATA_W-1:0]  cap [CHANNELS];
    logic [DATA_W-1:0]  cap_nxt [CHANNELS];
    logic [DATA_W-1:0]  shadow [CHANNELS];
    logic [DATA_W-1:0]  shadow_nxt [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready_d0  <= 1'b0;
            mem_ready_d1  <= 1'b0;
            record_key_d0 <= 1'b1;
            record_key_d1 <= 1'b1;
            play_key_d0   <= 1'b1;
            play_key_d1   <= 1'b1;
            rx_d0         <= 1'b0;
            rx_d1         <= 1'b0;
            tx_d0         <= 1'b0;
            tx_d1         <= 1'b0;
        end else begin
            mem_ready_d0  <= mem_ready;
            mem_ready_d1  <= mem_ready_d0;
            record_key_d0 <= record_key;
            record_key_d1 <= record_key_d0;
            play_key_d0   <= play_key;
            play_key_d1   <= play_key_d0;
            rx_d0         <= rx_done;
            rx_d1         <= rx_d0;
            tx_d0         <= tx_done;
            tx_d1         <= tx_d0;
        end
    end

    assign pos_rx   = rx_d0 & ~rx_d1;
    assign pos_tx   = tx_d0 & ~tx_d1;
    assign neg_play = ~play_key_d0 & play_key_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            beat      <= '0;
            frame_cnt <= '0;
            play_cnt  <= '0;
            rec_len   <= '0;
            rec_full  <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            wr_load   <= 1'b0;
            rd_en     <= 1'b0;
            rd_load   <= 1'b0;
            dac_pend  <= 1'b0;
            dac_data  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cap[c]    <= '0;
                shadow[c] <= '0;
            end
        end else begin
            st        <= st_nxt;
            beat      <= beat_nxt;
            frame_cnt <= frame_cnt_nxt;
            play_cnt  <= play_cnt_nxt;
            rec_len   <= rec_len_nxt;
            rec_full  <= rec_full_nxt;
            wr_en     <= wr_en_nxt;
            wr_data   <= wr_data_nxt;
            wr_load   <= wr_load_nxt;
            rd_en     <= rd_en_nxt;
            rd_load   <= rd_load_nxt;
            dac_pend  <= dac_pend_nxt;
            dac_data  <= dac_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                cap[c]    <= cap_nxt[c];
                shadow[c] <= shadow_nxt[c];
            end
        end
    end

    always_comb begin
        st_nxt        = st;
        beat_nxt      = beat;
        frame_cnt_nxt = frame_cnt;
        play_cnt_nxt  = play_cnt;
        rec_len_nxt   = rec_len;
        rec_full_nxt  = rec_full;
        wr_en_nxt     = 1'b0;
        wr_data_nxt   = '0;
        wr_load_nxt   = 1'b0;
        rd_en_nxt     = 1'b0;
        rd_load_nxt   = 1'b0;
        dac_pend_nxt  = 1'b0;
        dac_nxt       = dac_data;
        cap_nxt       = cap;
        shadow_nxt    = shadow;

        unique case (st)
            S_IDLE: begin
                if (!record_key_d1 && mem_ready_d1) begin
                    st_nxt        = S_REC;
                    wr_load_nxt   = 1'b1;
                    frame_cnt_nxt = '0;
                    rec_full_nxt  = 1'b0;
                end else if (neg_play && (rec_len != '0)) begin
                    st_nxt       = S_PLAY;
                    rd_load_nxt  = 1'b1;
                    play_cnt_nxt = '0;
                end
            end

            S_REC: begin
                // A burst in flight always finishes before the key release is honoured.
                if (wr_en) begin
                    if (beat == LAST_BEAT) begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                        if (frame_cnt_nxt == MAX_FRAMES)
                            rec_full_nxt = 1'b1;
                    end else begin
                        wr_en_nxt   = 1'b1;
                        beat_nxt    = beat + 1'b1;
                        wr_data_nxt = cap[beat_nxt];
                    end
                end else if (record_key_d1) begin
                    st_nxt      = S_IDLE;
                    rec_len_nxt = frame_cnt;
                end else if (pos_rx && (frame_cnt < MAX_FRAMES)) begin
                    for (int c = 0; c < CHANNELS; c++)
                        cap_nxt[c] = adc_data[c*DATA_W +: DATA_W];
                    wr_en_nxt   = 1'b1;
                    beat_nxt    = '0;
                    wr_data_nxt = adc_data[DATA_W-1:0];
                end
            end

            S_PLAY: begin
                if (!record_key_d1) begin
                    st_nxt  = S_IDLE;
                    dac_nxt = '0;
                end else if (neg_play) begin
                    rd_load_nxt  = 1'b1;
                    play_cnt_nxt = '0;
                end else if (rd_en) begin
                    shadow_nxt[beat] = buf_if.rd_data;
                    if (beat == LAST_BEAT) begin
                        dac_pend_nxt = 1'b1;
                    end else begin
                        rd_en_nxt = 1'b1;
                        beat_nxt  = beat + 1'b1;
                    end
                end else if (dac_pend) begin
                    for (int c = 0; c < CHANNELS; c++)
                        dac_nxt[c*DATA_W +: DATA_W] = shadow[c];
                    play_cnt_nxt = play_cnt + 1'b1;
                end else if (play_cnt == rec_len) begin
                    if (loop_en) begin
                        rd_load_nxt  = 1'b1;
                        play_cnt_nxt = '0;
                    end else begin
                        st_nxt  = S_IDLE;
                        dac_nxt = '0;
                    end
                end else if (pos_tx) begin
                    rd_en_nxt = 1'b1;
                    beat_nxt  = '0;
                end
            end

            default: st_nxt = S_IDLE;
        endcase
    end

    assign buf_if.wr_en   = wr_en;
    assign buf_if.wr_data = wr_data;
    assign buf_if.wr_load = wr_load;
    assign buf_if.rd_en   = rd_en;
    assign buf_if.rd_load = rd_load;
    assign state          = st;
endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench for audio_rec_play_ctrl: two channels, 16-bit samples and a
// four-frame recording limit, with a small FIFO model standing in for SDRAM.
module tb_audio_rec_play_ctrl;
    logic        clk;
    logic        rst;
    logic        mem_ready;
    logic        record_key;
    logic        play_key;
    logic        loop_en;
    logic        rx_done;
    logic        tx_done;
    logic [31:0] adc_data;
    logic [31:0] dac_data;
    logic [1:0]  state;
    logic        rec_full;
    logic [23:0] rec_len;

    int total = 0;
    int bad   = 0;

    audio_rec_play_ctrl_if #(.DATA_W(16)) buf_if ();

    audio_rec_play_ctrl #(
        .DATA_W(16), .CHANNELS(2), .FRAME_W(24), .MAX_FRAMES(24'd4)
    ) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .record_key(record_key),
        .play_key(play_key), .loop_en(loop_en), .rx_done(rx_done), .tx_done(tx_done),
        .adc_data(adc_data), .dac_data(dac_data), .buf_if(buf_if),
        .state(state), .rec_full(rec_full), .rec_len(rec_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: load pulses rewind the pointers, read data valid with rd_en
    logic [15:0] mem [16];
    logic [3:0]  wptr = '0;
    logic [3:0]  rptr = '0;
    always @(posedge clk) begin
        if (buf_if.wr_load) wptr <= '0;
        else if (buf_if.wr_en) begin
            mem[wptr] <= buf_if.wr_data;
            wptr      <= wptr + 4'd1;
        end
        if (buf_if.rd_load) rptr <= '0;
        else if (buf_if.rd_en) rptr <= rptr + 4'd1;
    end
    assign buf_if.rd_data = mem[rptr];

    int          cyc = 0;
    int          n_rd = 0, n_wrload = 0, n_rdload = 0;
    int          full_rise = -1;
    logic [15:0] wr_log [$];
    int          wr_cyc [$];
    logic [31:0] dac_log [$];
    logic [31:0] prev_dac = '0;
    logic        prev_full = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (buf_if.wr_en) begin
                wr_log.push_back(buf_if.wr_data);
                wr_cyc.push_back(cyc);
            end
            if (buf_if.rd_en)   n_rd++;
            if (buf_if.wr_load) n_wrload++;
            if (buf_if.rd_load) n_rdload++;
            if (dac_data !== prev_dac && dac_data !== 32'h0) dac_log.push_back(dac_data);
            if (rec_full && !prev_full) full_rise = cyc;
        end
        prev_dac  = dac_data;
        prev_full = rec_full;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int k = 0;
        while (state !== s && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 64'(state), 64'(s));
    endtask

    task automatic rx_pulse(input logic [31:0] d);
        adc_data = d;
        rx_done  = 1'b1;
        tick(); tick();
        rx_done  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic tx_pulse();
        tx_done = 1'b1;
        tick(); tick();
        tx_done = 1'b0;
        repeat (6) tick();
    endtask

    int b_wr, b_rd, b_rdl, b_wrl, b_dac, k;
    logic [15:0] exp_wr [6];
    logic [31:0] exp_loop [5];

    initial begin
        rst = 1'b1; mem_ready = 1'b0; record_key = 1'b1; play_key = 1'b1;
        loop_en = 1'b0; rx_done = 1'b0; tx_done = 1'b0; adc_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset_state", 64'(state), 64'(0));
        chk("reset_rec_len", 64'(rec_len), 64'(0));
        chk("reset_dac", 64'(dac_data), 64'(0));
        chk("reset_strobes", 64'({buf_if.wr_en, buf_if.rd_en, buf_if.wr_load, buf_if.rd_load}), 64'(0));
        chk("reset_full", 64'(rec_full), 64'(0));

        // play with nothing recorded is ignored
        play_key = 1'b0;
        repeat (5) tick();
        chk("play_empty_state", 64'(state), 64'(0));
        chk("play_empty_rdload", 64'(n_rdload), 64'(0));
        play_key = 1'b1;
        repeat (3) tick();

        // record three frames
        mem_ready = 1'b1;
        b_wr = wr_log.size(); b_wrl = n_wrload;
        record_key = 1'b0;
        wait_state(2'd1, "enter_rec");
        rx_pulse(32'hBBBB_AAAA);
        rx_pulse(32'hDDDD_CCCC);
        rx_pulse(32'hFFFF_EEEE);
        record_key = 1'b1;
        wait_state(2'd0, "rec_exit");
        chk("rec_len_3", 64'(rec_len), 64'(3));
        chk("rec_wrload", 64'(n_wrload - b_wrl), 64'(1));
        chk("rec_wr_count", 64'(wr_log.size() - b_wr), 64'(6));
        exp_wr = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
        if (wr_log.size() - b_wr == 6) begin
            for (int i = 0; i < 6; i++) chk("rec_wr_data", 64'(wr_log[b_wr+i]), 64'(exp_wr[i]));
            for (int i = 0; i < 3; i++) chk("rec_wr_pair", 64'(wr_cyc[b_wr+2*i+1] - wr_cyc[b_wr+2*i]), 64'(1));
        end

        // single-shot playback, fourth tx event falls in IDLE
        b_rd = n_rd; b_rdl = n_rdload; b_dac = dac_log.size();
        loop_en = 1'b0;
        play_key = 1'b0;
        wait_state(2'd2, "enter_play");
        play_key = 1'b1;
        repeat (3) tick();
        repeat (4) tx_pulse();
        chk("play_state_idle", 64'(state), 64'(0));
        chk("play_dac_clear", 64'(dac_data), 64'(0));
        chk("play_rd_count", 64'(n_rd - b_rd), 64'(6));
        chk("play_rdload", 64'(n_rdload - b_rdl), 64'(1));
        chk("play_frames", 64'(dac_log.size() - b_dac), 64'(3));
        if (dac_log.size() - b_dac == 3) begin
            chk("play_f1", 64'(dac_log[b_dac]),   64'(32'hBBBB_AAAA));
            chk("play_f2", 64'(dac_log[b_dac+1]), 64'(32'hDDDD_CCCC));
            chk("play_f3", 64'(dac_log[b_dac+2]), 64'(32'hFFFF_EEEE));
        end

        // six rx events against a four-frame limit
        b_wr = wr_log.size();
        record_key = 1'b0;
        wait_state(2'd1, "enter_rec_max");
        chk("full_cleared", 64'(rec_full), 64'(0));
        for (int i = 0; i < 3; i++) rx_pulse(32'h0010_0000 + 32'(i));
        chk("full_before", 64'(rec_full), 64'(0));
        rx_pulse(32'h0013_0003);
        chk("full_after", 64'(rec_full), 64'(1));
        chk("full_timing", 64'(full_rise - wr_cyc[wr_cyc.size()-1]), 64'(1));
        rx_pulse(32'h0014_0004);
        rx_pulse(32'h0015_0005);
        chk("max_wr_count", 64'(wr_log.size() - b_wr), 64'(8));
        record_key = 1'b1;
        wait_state(2'd0, "rec_max_exit");
        chk("rec_len_4", 64'(rec_len), 64'(4));

        // two-frame recording for looped playback
        record_key = 1'b0;
        wait_state(2'd1, "enter_rec_loop");
        rx_pulse(32'h2222_1111);
        rx_pulse(32'h4444_3333);
        record_key = 1'b1;
        wait_state(2'd0, "rec_loop_exit");
        chk("rec_len_2", 64'(rec_len), 64'(2));

        b_rdl = n_rdload; b_dac = dac_log.size();
        loop_en = 1'b1;
        play_key = 1'b0;
        wait_state(2'd2, "enter_play_loop");
        play_key = 1'b1;
        repeat (3) tick();
        repeat (5) tx_pulse();
        chk("loop_state", 64'(state), 64'(2));
        chk("loop_rdload", 64'(n_rdload - b_rdl), 64'(3));
        chk("loop_frames", 64'(dac_log.size() - b_dac), 64'(5));
        exp_loop = '{32'h2222_1111, 32'h4444_3333, 32'h2222_1111, 32'h4444_3333, 32'h2222_1111};
        if (dac_log.size() - b_dac == 5)
            for (int i = 0; i < 5; i++) chk("loop_order", 64'(dac_log[b_dac+i]), 64'(exp_loop[i]));

        // restart the pass, then press record during beat 1 of frame 1
        play_key = 1'b0;
        repeat (3) tick();
        play_key = 1'b1;
        repeat (4) tick();
        chk("restart_state", 64'(state), 64'(2));
        tx_done = 1'b1;
        tick();
        record_key = 1'b0;
        tick();
        chk("abort_beat0", 64'(buf_if.rd_en), 64'(1));
        tick();
        chk("abort_beat1", 64'(buf_if.rd_en), 64'(1));
        tick();
        chk("abort_rd_drop", 64'(buf_if.rd_en), 64'(0));
        chk("abort_dac", 64'(dac_data), 64'(0));
        chk("abort_idle", 64'(state), 64'(0));
        tick();
        chk("abort_rec", 64'(state), 64'(1));
        chk("abort_wrload", 64'(buf_if.wr_load), 64'(1));
        tx_done = 1'b0;
        repeat (4) tick();

        // reset in the middle of a write burst
        adc_data = 32'h5555_6666;
        rx_done  = 1'b1;
        k = 0;
        while (!buf_if.wr_en && k < 20) begin
            tick();
            k++;
        end
        chk("burst_started", 64'(buf_if.wr_en), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 64'(buf_if.wr_en), 64'(0));
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_rec_len", 64'(rec_len), 64'(0));
        chk("rst_outputs", 64'({dac_data, rec_full, buf_if.wr_load, buf_if.rd_en, buf_if.rd_load}), 64'(0));
        rx_done = 1'b0;
        record_key = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", 64'(state), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
